// File: rtl/alu_arbiter.sv
// Round-robin arbiter that time-shares one external combinational ALU among NREQ requesters.
// Operands are registered toward the ALU and results are registered back with valid/ready.
module alu_arbiter #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*XLEN-1:0] req_a,
  input  logic [NREQ*XLEN-1:0] req_b,
  input  logic [NREQ*4-1:0]    req_op,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [XLEN-1:0]      rsp_s,
  output logic [3:0]           rsp_nzvc,
  output logic                 rsp_hata,
  output logic [IDW-1:0]       rsp_id,
  output logic [XLEN-1:0]      alu_a,
  output logic [XLEN-1:0]      alu_b,
  output logic [3:0]           alu_op,
  input  logic [XLEN-1:0]      alu_s,
  input  logic                 alu_n,
  input  logic                 alu_z,
  input  logic                 alu_v,
  input  logic                 alu_c,
  input  logic                 alu_hata,
  output logic                 busy
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  localparam logic [IDW-1:0] LastInit = IDW'(NREQ - 1);

  state_e            r_state, w_state_next;
  logic [IDW-1:0]    r_last_grant;
  logic [XLEN-1:0]   r_alu_a, r_alu_b;
  logic [3:0]        r_alu_op;
  logic [XLEN-1:0]   r_rsp_s;
  logic [3:0]        r_rsp_nzvc;
  logic              r_rsp_hata;
  logic [IDW-1:0]    r_rsp_id;

  logic              w_found;
  logic [IDW-1:0]    w_grant;
  logic              w_accept;
  logic [XLEN-1:0]   w_sel_a, w_sel_b;
  logic [3:0]        w_sel_op;
  logic [NREQ-1:0]   w_grant_oh, w_rsp_oh;
  logic              w_rsp_take;

  // Two passes give the wrap-around search: indices above last_grant first, then the rest.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!w_found && req_valid[i] && (i > 32'(r_last_grant))) begin
        w_found = 1'b1;
        w_grant = IDW'(i);
      end
    end
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!w_found && req_valid[i]) begin
        w_found = 1'b1;
        w_grant = IDW'(i);
      end
    end
  end

  always_comb begin
    w_sel_a  = '0;
    w_sel_b  = '0;
    w_sel_op = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (w_grant == IDW'(i)) begin
        w_sel_a  = req_a[i*XLEN +: XLEN];
        w_sel_b  = req_b[i*XLEN +: XLEN];
        w_sel_op = req_op[i*4 +: 4];
      end
    end
  end

  always_comb begin
    w_grant_oh = '0;
    w_rsp_oh   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      w_grant_oh[i] = (w_grant == IDW'(i));
      w_rsp_oh[i]   = (r_rsp_id == IDW'(i));
    end
  end

  assign w_rsp_take = |(rsp_ready & w_rsp_oh);

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_found) begin
          w_accept     = 1'b1;
          w_state_next = StExec;
        end
      end
      StExec:  w_state_next = StResp;
      StResp:  if (w_rsp_take) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= StIdle;
      r_last_grant <= LastInit;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_op     <= '0;
      r_rsp_s      <= '0;
      r_rsp_nzvc   <= '0;
      r_rsp_hata   <= 1'b0;
      r_rsp_id     <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_alu_a      <= w_sel_a;
        r_alu_b      <= w_sel_b;
        r_alu_op     <= w_sel_op;
        r_rsp_id     <= w_grant;
        r_last_grant <= w_grant;
      end
      if (r_state == StExec) begin
        r_rsp_s    <= alu_s;
        r_rsp_nzvc <= {alu_n, alu_z, alu_v, alu_c};
        r_rsp_hata <= alu_hata;
      end
    end
  end

  // Handshake strobes are masked during reset so an aborted operation never completes.
  assign req_ready = (w_accept && !rst) ? w_grant_oh : '0;
  assign rsp_valid = ((r_state == StResp) && !rst) ? w_rsp_oh : '0;
  assign rsp_s     = r_rsp_s;
  assign rsp_nzvc  = r_rsp_nzvc;
  assign rsp_hata  = r_rsp_hata;
  assign rsp_id    = r_rsp_id;
  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_op    = r_alu_op;
  assign busy      = (r_state != StIdle);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus randomized traffic against a transaction-level
// reference; the bench also plays the external ALU.
module tb_alu_arbiter;
  localparam int unsigned XLEN = 32;
  localparam int unsigned NREQ = 4;
  localparam int unsigned IDW  = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_valid, req_ready, rsp_valid, rsp_ready;
  logic [NREQ*XLEN-1:0] req_a, req_b;
  logic [NREQ*4-1:0]    req_op;
  logic [XLEN-1:0]      rsp_s, alu_a, alu_b, alu_s;
  logic [3:0]           rsp_nzvc, alu_op;
  logic                 rsp_hata, alu_n, alu_z, alu_v, alu_c, alu_hata, busy;
  logic [IDW-1:0]       rsp_id;

  alu_arbiter #(.XLEN(XLEN), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_s(rsp_s), .rsp_nzvc(rsp_nzvc), .rsp_hata(rsp_hata), .rsp_id(rsp_id),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_s(alu_s), .alu_n(alu_n), .alu_z(alu_z), .alu_v(alu_v), .alu_c(alu_c),
    .alu_hata(alu_hata), .busy(busy)
  );

  always #5 clk = ~clk;

  // Bench ALU: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, anything else illegal. Returns {hata,n,z,v,c,s}.
  function automatic logic [XLEN+4:0] ref_alu(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                              input logic [3:0] op);
    logic [XLEN:0]   w;
    logic [XLEN-1:0] s;
    logic            v, c, h;
    v = 1'b0; c = 1'b0; h = 1'b0; s = '0;
    case (op)
      4'd0: begin
        w = {1'b0, a} + {1'b0, b};
        s = w[XLEN-1:0];
        c = w[XLEN];
        v = (a[XLEN-1] == b[XLEN-1]) && (s[XLEN-1] != a[XLEN-1]);
      end
      4'd1: begin
        s = a - b;
        c = (a >= b);
        v = (a[XLEN-1] != b[XLEN-1]) && (s[XLEN-1] != a[XLEN-1]);
      end
      4'd2: s = a & b;
      4'd3: s = a | b;
      4'd4: s = a ^ b;
      default: h = 1'b1;
    endcase
    return {h, s[XLEN-1], (s == '0), v, c, s};
  endfunction

  always_comb {alu_hata, alu_n, alu_z, alu_v, alu_c, alu_s} = ref_alu(alu_a, alu_b, alu_op);

  int checks = 0;
  int errors = 0;

  logic [NREQ-1:0] pend;
  logic [XLEN-1:0] pa [NREQ];
  logic [XLEN-1:0] pb [NREQ];
  logic [3:0]      pop [NREQ];
  int              last_g;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Round-robin rule: first pending requester after the last one served, wrapping around.
  function automatic int model_grant(input int last, input logic [NREQ-1:0] p);
    for (int k = 1; k <= int'(NREQ); k++) begin
      if (p[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic drive();
    req_valid = pend;
    for (int i = 0; i < int'(NREQ); i++) begin
      req_a[i*XLEN +: XLEN] = pa[i];
      req_b[i*XLEN +: XLEN] = pb[i];
      req_op[i*4 +: 4]      = pop[i];
    end
  endtask

  task automatic new_ops(input int i);
    pa[i]  = $urandom;
    pb[i]  = $urandom;
    pop[i] = 4'($urandom_range(0, 7));
  endtask

  task automatic arrive();
    for (int i = 0; i < int'(NREQ); i++) begin
      if (!pend[i] && $urandom_range(0, 3) == 0) begin
        new_ops(i);
        pend[i] = 1'b1;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pend = '0;
    rsp_ready = '0;
    drive();
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    last_g = NREQ - 1;
    drive(); #1;
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_rsp_s", rsp_s, 0);
    chk("rst_rsp_nzvc", rsp_nzvc, 0);
    chk("rst_rsp_hata", rsp_hata, 0);
    chk("rst_rsp_id", rsp_id, 0);
  endtask

  // One full transaction starting in an IDLE cycle with at least one request pending.
  task automatic do_txn(input int bp, input bit keep, input bit arr,
                        output logic [XLEN-1:0] os, output logic [3:0] onzvc,
                        output logic oh, output int og);
    logic [XLEN+4:0] e;
    logic [NREQ-1:0] oh_g;
    logic [XLEN-1:0] ea, eb;
    logic [3:0]      eop;
    int              g;
    os = '0; onzvc = '0; oh = 1'b0;
    drive(); #4;
    g  = model_grant(last_g, pend);
    og = g;
    if (g < 0) begin
      chk("txn_has_pending", 0, 1);
      return;
    end
    oh_g = NREQ'(1) << g;
    chk("grant_ready", req_ready, oh_g);
    chk("idle_busy", busy, 0);
    chk("idle_rsp_valid", rsp_valid, 0);
    ea = pa[g]; eb = pb[g]; eop = pop[g];
    e  = ref_alu(ea, eb, eop);
    @(posedge clk); #1;
    last_g = g;
    if (keep) new_ops(g);
    else pend[g] = 1'b0;
    if (arr) arrive();
    drive(); #4;
    chk("exec_busy", busy, 1);
    chk("exec_req_ready", req_ready, 0);
    chk("exec_rsp_valid", rsp_valid, 0);
    chk("exec_alu_a", alu_a, ea);
    chk("exec_alu_b", alu_b, eb);
    chk("exec_alu_op", alu_op, eop);
    @(posedge clk); #1;
    for (int c = 0; c <= bp; c++) begin
      if (arr) arrive();
      rsp_ready = (c == bp) ? (oh_g | NREQ'($urandom)) : (NREQ'($urandom) & ~oh_g);
      drive(); #4;
      chk("rsp_valid", rsp_valid, oh_g);
      chk("rsp_id", rsp_id, g);
      chk("rsp_s", rsp_s, e[XLEN-1:0]);
      chk("rsp_nzvc", rsp_nzvc, e[XLEN+3:XLEN]);
      chk("rsp_hata", rsp_hata, e[XLEN+4]);
      chk("rsp_req_ready", req_ready, 0);
      chk("rsp_busy", busy, 1);
      os = rsp_s; onzvc = rsp_nzvc; oh = rsp_hata;
      @(posedge clk); #1;
    end
    rsp_ready = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [XLEN-1:0] s;
    logic [3:0]      f;
    logic            h;
    int              g;
    int              rr_exp [5] = '{0, 1, 2, 3, 0};

    for (int i = 0; i < int'(NREQ); i++) begin
      pa[i] = '0; pb[i] = '0; pop[i] = '0;
    end
    do_reset();

    // Single ADD from requester 0.
    pa[0] = 32'd5; pb[0] = 32'd7; pop[0] = 4'd0; pend = 4'b0001;
    do_txn(0, 1'b0, 1'b0, s, f, h, g);
    chk("t1_sum", s, 32'd12);
    chk("t1_nzvc", f, 4'b0000);
    chk("t1_hata", h, 0);
    drive(); #4;
    chk("t1_back_idle", busy, 0);
    @(posedge clk); #1;

    // Signed overflow, then unsigned carry-out.
    pa[2] = 32'h7FFF_FFFF; pb[2] = 32'd1; pop[2] = 4'd0; pend = 4'b0100;
    do_txn(0, 1'b0, 1'b0, s, f, h, g);
    chk("t2_ovf_sum", s, 32'h8000_0000);
    chk("t2_ovf_nzvc", f, 4'b1010);
    chk("t2_ovf_id", g, 2);
    pa[2] = 32'hFFFF_FFFF; pb[2] = 32'd1; pop[2] = 4'd0; pend = 4'b0100;
    do_txn(0, 1'b0, 1'b0, s, f, h, g);
    chk("t2_carry_sum", s, 32'h0000_0000);
    chk("t2_carry_nzvc", f, 4'b0101);

    // Round-robin with every requester continuously valid.
    do_reset();
    for (int i = 0; i < int'(NREQ); i++) begin
      pa[i] = 32'(100 * (i + 1)); pb[i] = 32'(i + 3); pop[i] = 4'(i % 5);
    end
    pend = '1;
    for (int k = 0; k < 5; k++) begin
      do_txn(0, 1'b1, 1'b0, s, f, h, g);
      chk("t3_rr_order", g, rr_exp[k]);
    end

    // Backpressure on requester 1 while requester 3 waits.
    do_reset();
    pa[1] = 32'd40; pb[1] = 32'd2; pop[1] = 4'd1;
    pa[3] = 32'hF0F0; pb[3] = 32'h0FF0; pop[3] = 4'd2;
    pend = 4'b1010;
    do_txn(5, 1'b0, 1'b0, s, f, h, g);
    chk("t4_bp_id", g, 1);
    chk("t4_bp_sum", s, 32'd38);
    do_txn(0, 1'b0, 1'b0, s, f, h, g);
    chk("t4_next_id", g, 3);

    // Illegal opcode from requester 3.
    pa[3] = 32'd1; pb[3] = 32'd2; pop[3] = 4'hF; pend = 4'b1000;
    do_txn(0, 1'b0, 1'b0, s, f, h, g);
    chk("t5_hata", h, 1);

    // Reset during requester 1's EXEC cycle.
    do_reset();
    new_ops(0); new_ops(1);
    pend = 4'b0001;
    do_txn(0, 1'b0, 1'b0, s, f, h, g);
    pend = 4'b0011;
    drive(); #4;
    chk("t6_grant1", req_ready, 4'b0010);
    @(posedge clk); #1;
    rst = 1'b1;
    drive(); #4;
    chk("t6_in_exec", busy, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    last_g = NREQ - 1;
    drive(); #1;
    chk("t6_busy", busy, 0);
    chk("t6_rsp_valid", rsp_valid, 0);
    chk("t6_alu_a", alu_a, 0);
    chk("t6_alu_op", alu_op, 0);
    chk("t6_rsp_s", rsp_s, 0);
    chk("t6_rsp_id", rsp_id, 0);
    do_txn(0, 1'b0, 1'b0, s, f, h, g);
    chk("t6_next_grant", g, 0);

    // Random traffic with random arrivals, backpressure and idle gaps.
    for (int n = 0; n < 60; n++) begin
      if (pend == '0) begin
        if ($urandom_range(0, 1) == 0) begin
          drive(); #4;
          chk("rnd_idle_busy", busy, 0);
          chk("rnd_idle_ready", req_ready, 0);
          @(posedge clk); #1;
        end
        g = $urandom_range(0, NREQ - 1);
        new_ops(g);
        pend[g] = 1'b1;
      end
      do_txn($urandom_range(0, 3), 1'b0, 1'b1, s, f, h, g);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
